// File: rtl/matrix_stream_loader.sv
// Feeds the 5x5 transpose stage: takes a row-major element stream, maps it onto
// the fixed 25-slot grid (zero-padding unused slots) and issues gapped index/data strobes.
module matrix_stream_loader #(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [4:0]        elem_idx,
    output logic [DATA_W-1:0] elem_data,
    output logic              busy,
    output logic              load_done,
    output logic              len_err,
    output logic [9:0]        load_cycles
);

    typedef enum logic [2:0] {IDLE, FETCH, STROBE, GAP, DONE} state_t;

    localparam logic [2:0] ROW_LIM  = 3'(ROWS);
    localparam logic [2:0] COL_LIM  = 3'(COLS);
    localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
    localparam logic [2:0] COL_LAST = 3'(COLS - 1);

    state_t      state;
    state_t      state_next;
    logic [4:0]  pos;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        hold_cnt;
    logic        start_q;
    logic        slot_real;
    logic        slot_last_real;
    logic        accept;
    logic        begin_load;

    // Row/column of the current slot are tracked alongside pos to avoid a divider.
    assign slot_real      = (row < ROW_LIM) && (col < COL_LIM);
    assign slot_last_real = (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        begin_load = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_q) begin
                    state_next = FETCH;
                    begin_load = 1'b1;
                end
            end
            FETCH: begin
                if (slot_real) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept     = 1'b1;
                        state_next = STROBE;
                    end
                end else begin
                    state_next = STROBE;
                end
            end
            STROBE: begin
                if (hold_cnt) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = (pos == 5'd25) ? DONE : FETCH;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // start is registered, and only while a new load may begin; pulses during a load are lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q     <= 1'b0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            load_cycles <= '0;
        end else begin
            start_q   <= start && ((state == IDLE) || (state == DONE));
            busy      <= (state_next == FETCH) || (state_next == STROBE) || (state_next == GAP);
            load_done <= (state_next == DONE);
            if (begin_load) begin
                load_cycles <= '0;
            end else if (busy && (load_cycles != 10'd1023)) begin
                load_cycles <= load_cycles + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos       <= '0;
            row       <= '0;
            col       <= '0;
            hold_cnt  <= 1'b0;
            elem_idx  <= '0;
            elem_data <= '0;
            len_err   <= 1'b0;
        end else begin
            hold_cnt <= (state == STROBE) ? ~hold_cnt : 1'b0;
            if (begin_load) begin
                pos     <= 5'd1;
                row     <= '0;
                col     <= '0;
                len_err <= 1'b0;
            end
            if ((state == FETCH) && (state_next == STROBE)) begin
                elem_idx  <= pos;
                elem_data <= accept ? in_data : '0;
            end
            if ((state == STROBE) && (state_next == GAP)) begin
                elem_idx <= '0;
            end
            if ((state == GAP) && (state_next == FETCH)) begin
                pos <= pos + 5'd1;
                if (col == 3'd4) begin
                    col <= '0;
                    row <= row + 3'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end
            // Both an early in_last and a missing in_last on the final real slot are flagged.
            if (accept && (in_last != slot_last_real)) begin
                len_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Scoreboard bench for matrix_stream_loader: a 5x5 and a 3x3 instance share one
// stimulus path, selected by sel; expected slot events are queued per load.
module tb_matrix_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        sel;

    logic        rdy5, rdy3, busy5, busy3, done5, done3, err5, err3;
    logic [4:0]  idx5, idx3;
    logic [31:0] dat5, dat3;
    logic [9:0]  cyc5, cyc3;

    logic        in_ready, busy, load_done, len_err;
    logic [4:0]  elem_idx;
    logic [31:0] elem_data;
    logic [9:0]  load_cycles;

    always #5 clk = ~clk;

    assign in_ready    = sel ? rdy3 : rdy5;
    assign busy        = sel ? busy3 : busy5;
    assign load_done   = sel ? done3 : done5;
    assign len_err     = sel ? err3 : err5;
    assign elem_idx    = sel ? idx3 : idx5;
    assign elem_data   = sel ? dat3 : dat5;
    assign load_cycles = sel ? cyc3 : cyc5;

    matrix_stream_loader #(.ROWS(5), .COLS(5), .DATA_W(32)) u_dut5 (
        .clk(clk), .reset(reset), .start(start & ~sel), .in_valid(in_valid & ~sel),
        .in_data(in_data), .in_last(in_last), .in_ready(rdy5), .elem_idx(idx5),
        .elem_data(dat5), .busy(busy5), .load_done(done5), .len_err(err5),
        .load_cycles(cyc5)
    );

    matrix_stream_loader #(.ROWS(3), .COLS(3), .DATA_W(32)) u_dut3 (
        .clk(clk), .reset(reset), .start(start & sel), .in_valid(in_valid & sel),
        .in_data(in_data), .in_last(in_last), .in_ready(rdy3), .elem_idx(idx3),
        .elem_data(dat3), .busy(busy3), .load_done(done3), .len_err(err3),
        .load_cycles(cyc3)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_idx[$];
    int exp_data[$];

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobe monitor: pops one expected slot per rising index, checks 2-cycle hold and gaps.
    logic [4:0]  prev_idx = '0;
    int          run_len  = 0;
    logic [31:0] hold_data = '0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_idx = '0;
            run_len  = 0;
        end else begin
            if (elem_idx != 5'd0) begin
                if (prev_idx == 5'd0) begin
                    if (exp_idx.size() == 0) begin
                        check_output("sb_underflow", 32'(elem_idx), 32'd0);
                    end else begin
                        check_output("slot_idx", 32'(elem_idx), 32'(exp_idx.pop_front()));
                        check_output("slot_data", elem_data, 32'(exp_data.pop_front()));
                    end
                    run_len   = 1;
                    hold_data = elem_data;
                end else if (prev_idx == elem_idx) begin
                    run_len++;
                    check_output("data_stable", elem_data, hold_data);
                end else begin
                    check_output("idx_gap", 32'(prev_idx), 32'd0);
                    run_len   = 1;
                    hold_data = elem_data;
                end
            end else if (prev_idx != 5'd0) begin
                check_output("strobe_len", 32'(run_len), 32'd2);
            end
            prev_idx = elem_idx;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ready"}, 32'(in_ready), 32'd0);
        check_output({tag, "_idx"}, 32'(elem_idx), 32'd0);
        check_output({tag, "_data"}, elem_data, 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_done"}, 32'(load_done), 32'd0);
        check_output({tag, "_err"}, 32'(len_err), 32'd0);
        check_output({tag, "_cycles"}, 32'(load_cycles), 32'd0);
    endtask

    task automatic apply_stimulus(input bit use3, input int nbeats, input int base,
                                  input int last_at, input int stall_at, input int stall_len,
                                  input int err_beat, input int mid_start_idx, input int rst_idx,
                                  input int exp_cycles, input bit exp_err);
        int  dims;
        int  k;
        int  n;
        int  beat;
        int  accepted;
        int  stall_left;
        bit  chk_err;
        bit  mid_done;
        bit  aborted;
        dims = use3 ? 3 : 5;
        sel  = use3;
        k    = 0;
        for (int s = 1; s <= 25; s++) begin
            exp_idx.push_back(s);
            if (((s - 1) / 5 < dims) && ((s - 1) % 5 < dims)) begin
                exp_data.push_back(base + k);
                k++;
            end else begin
                exp_data.push_back(0);
            end
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("busy_edge0", 32'(busy), 32'd0);
        @(negedge clk);
        check_output("busy_edge1", 32'(busy), 32'd1);
        check_output("cycles_edge1", 32'(load_cycles), 32'd0);
        check_output("err_edge1", 32'(len_err), 32'd0);
        check_output("done_edge1", 32'(load_done), 32'd0);

        n          = 1;
        beat       = 1;
        accepted   = 0;
        stall_left = stall_len;
        chk_err    = 1'b0;
        mid_done   = 1'b0;
        aborted    = 1'b0;
        while (!load_done && (n <= 400) && !aborted) begin
            if (chk_err) begin
                check_output("len_err_post", 32'(len_err), 32'd1);
                chk_err = 1'b0;
            end
            if ((mid_start_idx != 0) && !mid_done && (elem_idx == 5'(mid_start_idx))) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
            if ((stall_left > 0) && ((stall_left < stall_len) || ((beat == stall_at) && in_ready))) begin
                if (stall_left < stall_len) begin
                    check_output("stall_ready", 32'(in_ready), 32'd1);
                end
                in_valid = 1'b0;
                stall_left--;
            end else begin
                in_valid = 1'b1;
                if (beat <= nbeats) begin
                    in_data = 32'(base + beat - 1);
                    in_last = (beat == last_at);
                end else begin
                    in_data = 32'hdead_beef;
                    in_last = 1'b0;
                end
                if (in_ready) begin
                    accepted++;
                    if (beat == err_beat) begin
                        check_output("len_err_pre", 32'(len_err), 32'd0);
                        chk_err = 1'b1;
                    end
                    beat++;
                end
            end
            if ((rst_idx != 0) && (elem_idx == 5'(rst_idx))) begin
                @(posedge clk);
                #2 reset = 1'b0;
                #1 check_reset_outputs("midrst");
                exp_idx.delete();
                exp_data.delete();
                in_valid = 1'b0;
                in_last  = 1'b0;
                aborted  = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
            end else begin
                @(negedge clk);
                n++;
                start = 1'b0;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        if (!aborted) begin
            check_output("done_edge", 32'(n), 32'(exp_cycles + 1));
            check_output("load_cycles", 32'(load_cycles), 32'(exp_cycles));
            check_output("len_err_final", 32'(len_err), 32'(exp_err));
            check_output("beats_taken", 32'(accepted), 32'(nbeats));
            check_output("busy_done", 32'(busy), 32'd0);
            check_output("idx_done", 32'(elem_idx), 32'd0);
            check_output("sb_left", 32'(exp_idx.size()), 32'd0);
            exp_idx.delete();
            exp_data.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        sel      = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // use3 nbeats base last stall_at stall_len err_beat mid_start rst_idx cycles err
        apply_stimulus(1'b0, 25, 1,  25, 0, 0, 0,  0, 0,  100, 1'b0);
        apply_stimulus(1'b1, 9,  10, 9,  0, 0, 0,  0, 0,  100, 1'b0);
        apply_stimulus(1'b0, 25, 1,  25, 7, 3, 0,  0, 0,  103, 1'b0);
        apply_stimulus(1'b0, 25, 40, 20, 0, 0, 20, 0, 0,  100, 1'b1);
        apply_stimulus(1'b0, 25, 70, 0,  0, 0, 0,  0, 0,  100, 1'b1);
        apply_stimulus(1'b0, 25, 5,  25, 0, 0, 0,  3, 0,  100, 1'b0);
        apply_stimulus(1'b0, 25, 1,  25, 0, 0, 0,  0, 12, 100, 1'b0);
        apply_stimulus(1'b0, 25, 100, 25, 0, 0, 0, 0, 0,  100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/matrix_stream_loader.md
# matrix_stream_loader

Upstream feeder for the 5x5 matrix transpose stage. Accepts matrix elements from the processor as a valid/ready stream in row-major order, places each into its slot of the fixed 5x5 grid (zero-padding unused slots when the matrix is smaller), and drives the transpose stage's element-index/element-data pair with stable, gapped strobes. It always issues all 25 slots, so the transpose stage sees slot 25 and starts every time. It also reports load status and the load cycle count.

## Interface
- ROWS, 5, matrix rows; legal 1..5
- COLS, 5, matrix columns; legal 1..5
- DATA_W, 32, element width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE or DONE
- in_valid  in  1  stream element valid
- in_data  in  DATA_W  stream element
- in_last  in  1  marks the final element of the matrix
- in_ready  out  1  loader accepts in_data this cycle
- elem_idx  out  5  slot index to transpose stage; 1..25 during strobe, 0 otherwise
- elem_data  out  DATA_W  slot value to transpose stage
- busy  out  1  high in FETCH/STROBE/GAP
- load_done  out  1  high in DONE
- len_err  out  1  sticky stream-length error
- load_cycles  out  10  cycles spent loading, saturating

## Operation
- Slot s (1..25) corresponds to r = (s-1)/5 and c = (s-1)%5. The slot is real if r<ROWS and c<COLS; otherwise it is pad.
- FSM states are IDLE, FETCH, STROBE, GAP and DONE.
- IDLE: in_ready=0, elem_idx=0. On start: go to FETCH, set pos=1, clear len_err, clear load_cycles, clear load_done.
- FETCH, real slot: in_ready=1. On in_valid&in_ready, capture in_data and go to STROBE. Otherwise stay.
- FETCH, pad slot: in_ready=0. Capture 0 and go to STROBE after exactly 1 cycle. No beat is consumed.
- STROBE: elem_idx=pos and elem_data=captured value, held for exactly 2 cycles. in_ready=0.
- GAP: elem_idx=0 for 1 cycle; elem_data holds its last value. in_ready=0. If pos==25, go to DONE. Otherwise pos+1 and go to FETCH.
- DONE: load_done=1, in_ready=0. A start restarts exactly as from IDLE.
- start is ignored in FETCH, STROBE and GAP.
- in_valid is ignored while in_ready=0, and such beats are not consumed.
- len_err is set (sticky until the next start) on either condition:
  - a beat accepted with in_last=1 that is not the last real slot;
  - the last real slot accepted with in_last=0.
- Loading continues after len_err is set; remaining real slots still consume beats.
- load_cycles increments once per cycle while busy=1 and saturates at 1023. It holds in DONE and IDLE.

## Timing
- Reset values: state=IDLE, pos=0, in_ready=0, elem_idx=0, elem_data=0, busy=0, load_done=0, len_err=0, load_cycles=0.
- Reset is asynchronous and applies mid-operation; the next load requires a new start.
- All outputs are registered, except in_ready, which is decoded from state and slot type.
- Per-slot cost with no stall: 4 cycles (FETCH 1 + STROBE 2 + GAP 1).
- Each cycle with in_valid=0 in a real-slot FETCH adds 1 cycle.
- start sampled at edge 0: busy=1 from edge 1. DONE is entered at edge 101 when no stalls occur, with load_cycles=100.
- elem_idx changes only on STROBE entry and GAP entry. Each nonzero index is preceded and followed by 0, so every slot is an event for the transpose stage.
- elem_data is stable for the entire time elem_idx is nonzero.

## Test plan
- Check 5x5 load with in_valid always 1, in_data = 1..25 and in_last on beat 25:
  - elem_idx steps through 1..25, each value held 2 cycles with a 0 between;
  - elem_data on slot s = s;
  - load_done at edge 101, load_cycles=100, len_err=0.
- Check ROWS=3, COLS=3 with beats 10..18, in_last on 18:
  - exactly 9 beats consumed;
  - slots 1,2,3,6,7,8,11,12,13 carry 10..18;
  - the other 16 slots carry 0;
  - slot 25 is issued; load_cycles=100.
- Check stalls: in the 5x5 load, drop in_valid for 3 cycles before beat 7.
  - in_ready stays 1 during the stall and the slot-7 data is correct;
  - load_cycles=103.
- Check length errors:
  - in_last on beat 20 of a 5x5 load: len_err=1 after beat 20 and the load still completes;
  - separate run with in_last=0 on beat 25: len_err=1;
  - a new start clears len_err.
- Check reset and start mid-load:
  - start pulsed while in STROBE is ignored;
  - deasserting reset during slot 12 gives all outputs their reset values immediately;
  - after release, a start reloads from slot 1.
